// File: rtl/sva_verdict_arb.sv
// Round-robin verdict arbiter: buffers one succ/fail/lazy verdict per checker and
// serializes them onto a valid/ready report channel with a gclk timestamp.
module sva_verdict_arb #(
  parameter int NCHK  = 4,
  parameter int TS_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic                     gclk,
  input  logic                     grst,
  input  logic [NCHK-1:0]          chk_succ,
  input  logic [NCHK-1:0]          chk_fail,
  input  logic [NCHK-1:0]          chk_lazy,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(NCHK)-1:0]  out_src,
  output logic [1:0]               out_kind,
  output logic [TS_W-1:0]          out_ts,
  output logic [CNT_W-1:0]         succ_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [NCHK-1:0]          ovf,
  output logic                     busy
);

  localparam int SRC_W = $clog2(NCHK);

  typedef enum logic [1:0] {
    K_NONE = 2'd0,
    K_SUCC = 2'd1,
    K_FAIL = 2'd2,
    K_LAZY = 2'd3
  } kind_e;

  logic [TS_W-1:0]  ts;
  logic [NCHK-1:0]  slot_vld;
  kind_e            slot_kind [NCHK];
  logic [TS_W-1:0]  slot_ts   [NCHK];
  logic [SRC_W-1:0] rr_ptr;

  logic             load_en;
  logic             accept;
  logic             gnt_any;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W-1:0] scan_idx;
  logic [SRC_W-1:0] rr_nxt;
  logic [NCHK-1:0]  gnt_oh;
  logic [NCHK-1:0]  evt;
  logic [NCHK-1:0]  ovf_set;
  kind_e            new_kind [NCHK];

  assign load_en = !out_valid || out_ready;
  assign accept  = out_valid && out_ready;
  assign busy    = (|slot_vld) || out_valid;

  // First valid slot at or above rr_ptr, wrapping modulo NCHK.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NCHK; k++) begin
      scan_idx = SRC_W'((32'(rr_ptr) + k) % NCHK);
      if (!gnt_any && slot_vld[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    gnt_oh = '0;
    if (load_en && gnt_any) gnt_oh[gnt_idx] = 1'b1;
    rr_nxt = (gnt_idx == SRC_W'(NCHK - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Per-checker capture: fail > succ > lazy; drops and multi-pulses flag ovf.
  always_comb begin
    for (int unsigned i = 0; i < NCHK; i++) begin
      evt[i] = chk_succ[i] | chk_fail[i] | chk_lazy[i];
      if (chk_fail[i])      new_kind[i] = K_FAIL;
      else if (chk_succ[i]) new_kind[i] = K_SUCC;
      else if (chk_lazy[i]) new_kind[i] = K_LAZY;
      else                  new_kind[i] = K_NONE;
      ovf_set[i] = (chk_succ[i] & chk_fail[i]) | (chk_succ[i] & chk_lazy[i]) |
                   (chk_fail[i] & chk_lazy[i]) |
                   (evt[i] & slot_vld[i] & ~gnt_oh[i]);
    end
  end

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      ts        <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_src   <= '0;
      out_kind  <= K_NONE;
      out_ts    <= '0;
      succ_cnt  <= '0;
      fail_cnt  <= '0;
      ovf       <= '0;
      slot_vld  <= '0;
      for (int unsigned i = 0; i < NCHK; i++) begin
        slot_kind[i] <= K_NONE;
        slot_ts[i]   <= '0;
      end
    end else begin
      ts <= ts + 1'b1;

      if (load_en) begin
        if (gnt_any) begin
          out_valid <= 1'b1;
          out_src   <= gnt_idx;
          out_kind  <= slot_kind[gnt_idx];
          out_ts    <= slot_ts[gnt_idx];
          rr_ptr    <= rr_nxt;
        end else begin
          out_valid <= 1'b0;
        end
      end

      // A slot being granted this edge may take a fresh verdict on the same edge.
      for (int unsigned i = 0; i < NCHK; i++) begin
        if (evt[i] && (!slot_vld[i] || gnt_oh[i])) begin
          slot_vld[i]  <= 1'b1;
          slot_kind[i] <= new_kind[i];
          slot_ts[i]   <= ts;
        end else if (gnt_oh[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end

      if (clr) begin
        succ_cnt <= '0;
        fail_cnt <= '0;
        ovf      <= '0;
      end else begin
        if (accept && out_kind == K_SUCC && succ_cnt != '1) succ_cnt <= succ_cnt + 1'b1;
        if (accept && out_kind == K_FAIL && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        ovf <= ovf | ovf_set;
      end
    end
  end

endmodule

// File: tb/tb_sva_verdict_arb.sv
// Directed bench for sva_verdict_arb: a default-size instance plus a narrow
// instance (TS_W=4, CNT_W=2) for saturation and timestamp wrap.
module tb_sva_verdict_arb;

  logic gclk = 1'b0;
  logic grst = 1'b1;
  always #5 gclk = ~gclk;

  logic [3:0]  succ, fail, lazy;
  logic        clr, ready;
  logic        out_valid, busy;
  logic [1:0]  out_src, out_kind;
  logic [15:0] out_ts, succ_cnt, fail_cnt;
  logic [3:0]  ovf;

  logic [1:0]  s_succ;
  logic        s_valid, s_busy;
  logic [0:0]  s_src;
  logic [1:0]  s_kind;
  logic [3:0]  s_ts;
  logic [1:0]  s_scnt, s_fcnt, s_ovf;

  sva_verdict_arb #(.NCHK(4), .TS_W(16), .CNT_W(16)) u_dut (
    .gclk(gclk), .grst(grst), .chk_succ(succ), .chk_fail(fail), .chk_lazy(lazy),
    .clr(clr), .out_valid(out_valid), .out_ready(ready), .out_src(out_src),
    .out_kind(out_kind), .out_ts(out_ts), .succ_cnt(succ_cnt), .fail_cnt(fail_cnt),
    .ovf(ovf), .busy(busy)
  );

  sva_verdict_arb #(.NCHK(2), .TS_W(4), .CNT_W(2)) u_small (
    .gclk(gclk), .grst(grst), .chk_succ(s_succ), .chk_fail(2'b00), .chk_lazy(2'b00),
    .clr(1'b0), .out_valid(s_valid), .out_ready(1'b1), .out_src(s_src),
    .out_kind(s_kind), .out_ts(s_ts), .succ_cnt(s_scnt), .fail_cnt(s_fcnt),
    .ovf(s_ovf), .busy(s_busy)
  );

  // Bench-side timestamp: the value the DUT samples on the next edge.
  logic [15:0] tb_ts;
  always @(posedge gclk or posedge grst) begin
    if (grst) tb_ts <= '0;
    else      tb_ts <= tb_ts + 16'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic [3:0] f, input logic [3:0] l);
    succ = s; fail = f; lazy = l;
    tick();
    succ = '0; fail = '0; lazy = '0;
  endtask

  task automatic goto_ts(input logic [15:0] n);
    int g = 0;
    while (tb_ts != n && g < 200) begin tick(); g++; end
    check("goto_ts", 32'(tb_ts), 32'(n));
  endtask

  task automatic goto_lo(input logic [3:0] n);
    int g = 0;
    while (tb_ts[3:0] != n && g < 40) begin tick(); g++; end
    check("goto_lo", 32'(tb_ts[3:0]), 32'(n));
  endtask

  int exp_v  [7] = '{0, 1, 1, 1, 1, 1, 0};
  int exp_ts [7] = '{0, 13, 14, 15, 0, 1, 0};
  int exp_c  [7] = '{0, 0, 1, 2, 3, 3, 3};

  initial begin
    succ = '0; fail = '0; lazy = '0; clr = 1'b0; ready = 1'b1; s_succ = '0;
    tick(); tick();
    grst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_succ", 32'(succ_cnt), 0);
    check("rst_fail", 32'(fail_cnt), 0);
    check("rst_ovf", 32'(ovf), 0);

    // Stall a record from checker 3, then overflow its slot; reset mid-transfer.
    goto_ts(16'd6);
    drive(4'b1000, 4'b0000, 4'b0000);
    ready = 1'b0;
    drive(4'b1000, 4'b0000, 4'b0000);
    drive(4'b1000, 4'b0000, 4'b0000);
    check("pre_valid", 32'(out_valid), 1);
    check("pre_src", 32'(out_src), 3);
    check("pre_ts", 32'(out_ts), 6);
    check("pre_ovf", 32'(ovf), 32'h8);
    #2 grst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_src", 32'(out_src), 0);
    check("mid_rst_kind", 32'(out_kind), 0);
    check("mid_rst_ts", 32'(out_ts), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_busy", 32'(busy), 0);
    tick();
    grst = 1'b0;
    ready = 1'b1;

    // Timestamps 0,1,2 from checker 3 back-to-back, then fail burst at ts=3.
    drive(4'b1000, 4'b0000, 4'b0000);
    check("lat_valid0", 32'(out_valid), 0);
    check("lat_busy", 32'(busy), 1);
    drive(4'b1000, 4'b0000, 4'b0000);
    check("ts0", 32'(out_ts), 0);
    check("ts0_src", 32'(out_src), 3);
    drive(4'b1000, 4'b0000, 4'b0000);
    check("ts1", 32'(out_ts), 1);
    drive(4'b0000, 4'b1111, 4'b0000);
    check("ts2", 32'(out_ts), 2);
    check("ts2_kind", 32'(out_kind), 1);
    check("no_ovf_regrant", 32'(ovf), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_fail_src", 32'(out_src), 32'(k));
      check("rr_fail_kind", 32'(out_kind), 2);
      check("rr_fail_ts", 32'(out_ts), 3);
    end
    drive(4'b0000, 4'b0000, 4'b1111);
    check("burst_end_valid", 32'(out_valid), 0);
    check("fail_cnt4", 32'(fail_cnt), 4);
    check("succ_cnt3", 32'(succ_cnt), 3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_lazy_src", 32'(out_src), 32'(k));
      check("rr_lazy_kind", 32'(out_kind), 3);
    end
    tick();
    check("idle_busy", 32'(busy), 0);
    check("lazy_not_counted", 32'(succ_cnt), 3);

    // Two-edge latency.
    goto_ts(16'd20);
    drive(4'b0100, 4'b0000, 4'b0000);
    check("lat_not_yet", 32'(out_valid), 0);
    tick();
    check("lat_valid", 32'(out_valid), 1);
    check("lat_src", 32'(out_src), 2);
    check("lat_kind", 32'(out_kind), 1);
    check("lat_ts", 32'(out_ts), 20);
    tick();
    check("lat_cnt", 32'(succ_cnt), 4);

    // Backpressure: held record, lazy buffered, later succ lost.
    goto_ts(16'd28);
    ready = 1'b0;
    drive(4'b0001, 4'b0000, 4'b0000);
    tick();
    drive(4'b0000, 4'b0000, 4'b0010);
    tick();
    drive(4'b0010, 4'b0000, 4'b0000);
    check("bp_ovf", 32'(ovf), 32'h2);
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_src", 32'(out_src), 0);
    check("bp_hold_ts", 32'(out_ts), 28);
    ready = 1'b1;
    tick();
    check("bp_src", 32'(out_src), 1);
    check("bp_kind", 32'(out_kind), 3);
    check("bp_ts", 32'(out_ts), 30);
    tick();
    check("bp_drop_valid", 32'(out_valid), 0);
    check("bp_drop_busy", 32'(busy), 0);
    check("bp_cnt", 32'(succ_cnt), 5);

    // Same-edge succ+fail, then clr on the accept edge.
    drive(4'b0001, 4'b0001, 4'b0000);
    tick();
    check("prio_src", 32'(out_src), 0);
    check("prio_kind", 32'(out_kind), 2);
    check("prio_ovf", 32'(ovf), 32'h3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_fail", 32'(fail_cnt), 0);
    check("clr_succ", 32'(succ_cnt), 0);
    check("clr_ovf", 32'(ovf), 0);
    check("clr_valid", 32'(out_valid), 0);

    // Narrow instance: 2-bit saturation and 4-bit timestamp wrap.
    goto_lo(4'd13);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) s_succ = 2'b01;
      tick();
      s_succ = 2'b00;
      check("sm_valid", 32'(s_valid), 32'(exp_v[i]));
      if (exp_v[i] != 0) check("sm_ts", 32'(s_ts), 32'(exp_ts[i]));
      check("sm_cnt", 32'(s_scnt), 32'(exp_c[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
